stage3: RTL and testbench
=========================

STAGE3 -- requirements
Module: stage3

Interface
REQ-001 The block SHALL have these parameters: ROUNDS, default 4, number of exam rounds; PASS_TH, default 24, minimum score for pass3.
REQ-002 The block SHALL have these ports, one per line:
  clk  input  1  rising-edge clock
  rst_n  input  1  asynchronous active-low reset
  start  input  1  request pulse; sampled only in IDLE
  pass2  input  1  pass flag from the preceding stage
  bonus2  input  2  bonus level from the preceding stage
  effort  input  7  effort value, unsigned
  random3  input  5  per-round random sample
  busy  output  1  high in EXAM and DONE
  done  output  1  one-cycle result strobe
  pass3  output  1  final pass flag, held
  grade  output  2  final grade 0..3, held
REQ-003 The block SHALL use one clock (clk) and an asynchronous active-low reset (rst_n).

Function
REQ-004 The block SHALL implement three states: IDLE, EXAM and DONE.
REQ-005 In IDLE, when start=1 at clock edge E0, the block SHALL latch pass2, bonus2 and effort.
REQ-006 If pass2=0 at E0, the block SHALL go to DONE with pass3=0 and grade=0 (fail-fast).
REQ-007 If pass2=1 at E0, the block SHALL go to EXAM with round=0 and score=base.
REQ-008 base SHALL equal effort[6:3] + 2*bonus2, computed as an unsigned 6-bit value (range 0..21).
REQ-009 In EXAM, the block SHALL sample random3 at each edge E1..E(ROUNDS).
REQ-010 Each sampled random3 SHALL add random3[2:0] to score when random3[4:3]!=2'b00, and SHALL add 0 otherwise (question missed).
REQ-011 score SHALL be 6-bit unsigned, with maximum 21+4*7=49, so that no wrap occurs.
REQ-012 At edge E(ROUNDS), the block SHALL go to DONE and register pass3 and grade from the final score.
REQ-013 pass3 SHALL be 1 when score>=PASS_TH.
REQ-014 grade SHALL be 3 when score>=42, 2 when score>=36, 1 when score>=30, and 0 otherwise; grade SHALL be forced to 0 when pass3=0.
REQ-015 done SHALL be 1 for exactly the single cycle spent in DONE.
REQ-016 From DONE, the block SHALL always return to IDLE at the next edge.
REQ-017 Latency from start to done SHALL be 1 cycle on the fail-fast path and ROUNDS+1 cycles on the exam path.
REQ-018 A start while busy=1 SHALL be ignored; it SHALL NOT be queued and SHALL NOT restart the exam.
REQ-019 A start in the same cycle as the DONE-to-IDLE transition SHALL be ignored; start is accepted only in IDLE.
REQ-020 pass3 and grade SHALL hold their values from DONE until the next result is registered.
REQ-021 Changes to pass2, bonus2 or effort after E0 SHALL NOT affect the result.

Reset
REQ-022 While rst_n=0, the block SHALL force state=IDLE and round=0, score=0, busy=0, done=0, pass3=0 and grade=0, regardless of clk.
REQ-023 A reset in the middle of EXAM or DONE SHALL abort the operation without emitting done; the first start after reset release SHALL be handled normally.

Structure
REQ-024 The state encoding, the grade thresholds (30/36/42), the PASS_TH default and the score width SHALL be defined in shared package ge_pkg.
REQ-025 The per-round scoring (random3 to 0..7 points) SHALL be a combinational sub-module named ge_round_score.
REQ-026 The FSM, round counter and score accumulator SHALL reside in stage3.

Verification
REQ-027 Fail-fast: pass2=0 and start=1 -> done high in the next cycle, pass3=0, grade=0, busy high for 1 cycle.
REQ-028 Nominal: effort=64, bonus2=0, random3=5'b11111 for 4 rounds -> score 36, done 5 cycles after start, pass3=1, grade=2.
REQ-029 Maximum: effort=127, bonus2=3, random3=5'b01111 for 4 rounds -> score 49, pass3=1, grade=3, no overflow.
REQ-030 Threshold edge and missed questions: effort=64, bonus2=0, random3=5'b01100 for 4 rounds -> score 24, pass3=1, grade=0.
REQ-031 Missed questions: effort=80, bonus2=1, random3=5'b00111 for all rounds -> score 12, pass3=0, grade=0.
REQ-032 Robustness: start pulsed during round 2 -> ignored, single done only; rst_n low during round 3 -> outputs 0 immediately, no done; a new start after release gives a correct result.

Source files
------------

// File: rtl/ge_pkg.sv
// Shared definitions for the exam stage: state encoding, score width, pass/grade thresholds.
// Grading helper used when the final score is registered.
package ge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXAM = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SCORE_W     = 6;
   localparam int PASS_TH_DEF = 24;

   localparam logic [SCORE_W-1:0] GRADE1_TH = 6'd30;
   localparam logic [SCORE_W-1:0] GRADE2_TH = 6'd36;
   localparam logic [SCORE_W-1:0] GRADE3_TH = 6'd42;

   // A failing score always grades 0, whatever the raw score says.
   function automatic logic [1:0] grade_of(input logic [SCORE_W-1:0] score, input logic pass);
      logic [1:0] g;
      if (score >= GRADE3_TH)      g = 2'd3;
      else if (score >= GRADE2_TH) g = 2'd2;
      else if (score >= GRADE1_TH) g = 2'd1;
      else                         g = 2'd0;
      return pass ? g : 2'd0;
   endfunction

endpackage

// File: rtl/ge_round_score.sv
// Per-round scoring: a random sample is worth random3[2:0] points unless the
// question was missed (random3[4:3] == 0), in which case it is worth nothing.
module ge_round_score (
   input  logic [4:0] random3,
   output logic [2:0] points
);

   assign points = (random3[4:3] != 2'b00) ? random3[2:0] : 3'd0;

endmodule

// File: rtl/stage3.sv
// Exam stage: fail-fast on a failed preceding stage, otherwise accumulate
// ROUNDS random samples onto a base score and register pass3/grade.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting for start; inputs are captured on the accepting edge
//   ST_EXAM | one random3 sample is scored per cycle, ROUNDS cycles
//   ST_DONE | result registered, done strobe for this one cycle
module stage3
   import ge_pkg::*;
#(
   parameter int ROUNDS  = 4,
   parameter int PASS_TH = PASS_TH_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pass2,
   input  logic [1:0] bonus2,
   input  logic [6:0] effort,
   input  logic [4:0] random3,
   output logic       busy,
   output logic       done,
   output logic       pass3,
   output logic [1:0] grade
);

   localparam int ROUND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);
   localparam logic [SCORE_W-1:0] PASS_TH_S  = SCORE_W'(PASS_TH);

   state_t               state, state_nxt;
   logic [ROUND_W-1:0]   round, round_nxt;
   logic [SCORE_W-1:0]   score, score_nxt;
   logic                 pass3_nxt;
   logic [1:0]           grade_nxt;
   logic [2:0]           points;
   logic [SCORE_W-1:0]   base;
   logic                 effort_lsb_unused;

   // Only the coarse effort bits contribute to the base score.
   assign effort_lsb_unused = ^effort[2:0];
   assign base = {2'b00, effort[6:3]} + {3'b000, bonus2, 1'b0};

   ge_round_score u_round_score (
      .random3 (random3),
      .points  (points)
   );

   always_comb begin
      state_nxt = state;
      round_nxt = round;
      score_nxt = score;
      pass3_nxt = pass3;
      grade_nxt = grade;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (pass2) begin
                  state_nxt = ST_EXAM;
                  round_nxt = '0;
                  score_nxt = base;
               end else begin
                  state_nxt = ST_DONE;
                  pass3_nxt = 1'b0;
                  grade_nxt = 2'd0;
               end
            end
         end
         ST_EXAM: begin
            score_nxt = score + {3'b000, points};
            if (round == ROUND_LAST) begin
               state_nxt = ST_DONE;
               pass3_nxt = (score_nxt >= PASS_TH_S);
               grade_nxt = grade_of(score_nxt, score_nxt >= PASS_TH_S);
            end else begin
               round_nxt = round + ROUND_W'(1);
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         round <= '0;
         score <= '0;
         pass3 <= 1'b0;
         grade <= 2'd0;
      end else begin
         state <= state_nxt;
         round <= round_nxt;
         score <= score_nxt;
         pass3 <= pass3_nxt;
         grade <= grade_nxt;
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_stage3.sv
// Directed bench for stage3: hand-computed exam results, latency, hold,
// ignored starts and mid-exam reset.
module tb_stage3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       pass2 = 1'b0;
   logic [1:0] bonus2 = 2'd0;
   logic [6:0] effort = 7'd0;
   logic [4:0] random3 = 5'd0;
   logic       busy, done, pass3;
   logic [1:0] grade;

   int checks = 0;
   int failures = 0;

   stage3 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .pass2   (pass2),
      .bonus2  (bonus2),
      .effort  (effort),
      .random3 (random3),
      .busy    (busy),
      .done    (done),
      .pass3   (pass3),
      .grade   (grade)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // rv[4:0] is the round-1 sample, rv[19:15] the round-4 sample.
   task automatic run_exam(input string tag, input logic p2, input logic [1:0] b2,
                           input logic [6:0] eff, input logic [19:0] rv,
                           input logic exp_pass, input logic [1:0] exp_grade,
                           input int glitch, input bit start_in_done);
      int n;
      int idx;
      start = 1'b1; pass2 = p2; bonus2 = b2; effort = eff; random3 = 5'd0;
      step();
      start = 1'b0; pass2 = ~p2; bonus2 = ~b2; effort = ~eff;
      check({tag, "_busy_e0"}, 32'(busy), 32'd1);
      n = 1;
      while (!done && n < 20) begin
         idx = (n <= 4) ? n - 1 : 0;
         random3 = rv[5*idx +: 5];
         start = (glitch != 0 && n == glitch);
         step();
         n++;
      end
      start = 1'b0;
      check({tag, "_latency"}, 32'(n), p2 ? 32'd5 : 32'd1);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_pass3"}, 32'(pass3), 32'(exp_pass));
      check({tag, "_grade"}, 32'(grade), 32'(exp_grade));
      check({tag, "_busy_done"}, 32'(busy), 32'd1);
      if (start_in_done) begin
         start = 1'b1; pass2 = 1'b0;
      end
      step();
      start = 1'b0;
      check({tag, "_done_1cyc"}, 32'(done), 32'd0);
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
      check({tag, "_pass3_hold"}, 32'(pass3), 32'(exp_pass));
      check({tag, "_grade_hold"}, 32'(grade), 32'(exp_grade));
      if (glitch != 0 || start_in_done) begin
         for (int k = 0; k < 3; k++) begin
            step();
            check({tag, "_no_requeue"}, 32'({busy, done}), 32'd0);
         end
      end
   endtask

   initial begin
      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass3", 32'(pass3), 32'd0);
      check("rst_grade", 32'(grade), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Fail-fast; a start in the DONE cycle must be dropped.
      run_exam("failfast", 1'b0, 2'd3, 7'd127, {4{5'b11111}}, 1'b0, 2'd0, 0, 1'b1);
      // base 8 + 4*7 = 36
      run_exam("nominal", 1'b1, 2'd0, 7'd64, {4{5'b11111}}, 1'b1, 2'd2, 0, 1'b0);
      // base 15+6 = 21, + 4*7 = 49
      run_exam("maximum", 1'b1, 2'd3, 7'd127, {4{5'b01111}}, 1'b1, 2'd3, 0, 1'b0);
      // base 8 + 4*4 = 24
      run_exam("thresh24", 1'b1, 2'd0, 7'd64, {4{5'b01100}}, 1'b1, 2'd0, 0, 1'b0);
      // base 8 + 4+4+4+3 = 23
      run_exam("below23", 1'b1, 2'd0, 7'd64, {5'b01011, 5'b01100, 5'b01100, 5'b01100}, 1'b0, 2'd0, 0, 1'b0);
      // base 12+4 = 16, + 5 + 0 + 6 + 3 = 30
      run_exam("grade1_30", 1'b1, 2'd2, 7'd100, {5'b11011, 5'b10110, 5'b00111, 5'b01101}, 1'b1, 2'd1, 0, 1'b0);
      // base 10+2 = 12, all missed
      run_exam("missed12", 1'b1, 2'd1, 7'd80, {4{5'b00111}}, 1'b0, 2'd0, 0, 1'b0);
      // start pulsed during round 2 must not restart or queue
      run_exam("glitch", 1'b1, 2'd0, 7'd64, {4{5'b11111}}, 1'b1, 2'd2, 2, 1'b0);

      // Reset during round 3 aborts, outputs clear immediately.
      start = 1'b1; pass2 = 1'b1; bonus2 = 2'd0; effort = 7'd64; random3 = 5'b11111;
      step();
      start = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_pass3", 32'(pass3), 32'd0);
      check("midrst_grade", 32'(grade), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("midrst_no_done", 32'({busy, done}), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_rst_idle", 32'({busy, done}), 32'd0);
      run_exam("post_rst", 1'b1, 2'd3, 7'd127, {4{5'b01111}}, 1'b1, 2'd3, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

endmodule
